bus_drive_arbiter: RTL and testbench
====================================

BUS_DRIVE_ARBITER -- requirements
Module: bus_drive_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter MAX_HOLD SHALL default to 15 and SHALL set the maximum number of extra cycles a locked owner keeps the bus (legal range 1..15).
REQ-003 Port clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 Port req  in  24  SHALL carry bus-drive requests: bit0..15 = R0..R15, bit16 HI, bit17 LO, bit18 ZHI, bit19 ZLO, bit20 PC, bit21 MDR, bit22 InPort, bit23 C.
REQ-006 Port lock  in  1  SHALL be asserted by the current owner to hold the bus beyond one cycle.
REQ-007 Port grant  out  24  SHALL be a registered one-hot (or all-zero) drive enable, with the same bit order as req.
REQ-008 Port busSelect  out  5  SHALL be the registered encoded owner: 0 = none, else owner bit index + 1 (R0 = 1 ... C = 24).
REQ-009 Port busValid  out  1  SHALL be high exactly when grant is non-zero.
REQ-010 Port holdTimeout  out  1  SHALL be a one-cycle registered pulse marking a forced release.

Function
REQ-011 States SHALL be IDLE, GRANT and HOLD.
REQ-012 All outputs SHALL be registered; req sampled at edge N SHALL produce grant, busSelect and busValid after edge N (latency 1 cycle).
REQ-013 IDLE: if req is zero, the block SHALL stay in IDLE with grant 0; otherwise it SHALL grant the arbitration winner and go to GRANT.
REQ-014 Default arbitration SHALL be fixed priority, with the lowest bit index winning (R0 highest, C lowest).
REQ-015 GRANT or HOLD with lock=1, req[owner]=1 and holdCount<MAX_HOLD: the block SHALL keep the same owner, increment holdCount, and go to or remain in HOLD.
REQ-016 GRANT or HOLD with lock=0 or req[owner]=0: the block SHALL re-arbitrate over current req, grant the winner (GRANT), or go to IDLE if req is zero; back-to-back grants SHALL have no idle gap.
REQ-017 holdCount (4 bits) SHALL clear to 0 on every new grant, including a re-grant to the same requester.
REQ-018 HOLD with lock=1, req[owner]=1 and holdCount==MAX_HOLD: the block SHALL force release, pulse holdTimeout for one cycle, and re-arbitrate with the old owner masked for that single arbitration.
REQ-019 If a forced release finds no other request, the block SHALL go to IDLE for one cycle before it re-grants the old owner.
REQ-020 Requests that arrive while another requester holds the bus SHALL wait; there SHALL be no preemption except by REQ-018.
REQ-021 grant SHALL never have more than one bit set, and busSelect SHALL always equal the encoding of grant.

Reset
REQ-022 While reset_n=0, the block SHALL asynchronously force state IDLE, grant 0, busSelect 0, busValid 0, holdTimeout 0, holdCount 0 and rrPointer 23.
REQ-023 Reset during GRANT or HOLD SHALL drop grant immediately, without waiting for a clock edge.
REQ-024 The first arbitration after reset_n rises SHALL use the normal arbitration rules.

Configuration
REQ-025 When BUS_ARB_ROUND_ROBIN_EN is defined, arbitration SHALL be round-robin: the search starts at rrPointer+1, wraps from bit 23 to bit 0, and rrPointer updates to each new owner.
REQ-026 When BUS_ARB_ROUND_ROBIN_EN is undefined, arbitration SHALL be the fixed priority of REQ-014, and rrPointer SHALL be absent or unused.

Verification
REQ-027 Scenario: reset released, req=0x000005 for one cycle -> next cycle grant=0x000001, busSelect=1; the following cycle with req=0 -> IDLE, busSelect=0.
REQ-028 Scenario: req bits 20 and 21 held, lock=0, fixed priority -> busSelect=21 every cycle; with BUS_ARB_ROUND_ROBIN_EN -> busSelect alternates 21, 22, 21, 22.
REQ-029 Scenario: req[16]=1 with lock=1 held, MAX_HOLD=15 -> busSelect=17 for 16 cycles, then holdTimeout=1 and grant=0 for one cycle, then busSelect=17 again.
REQ-030 Scenario: owner bit 3 locked, req[0] rises mid-hold -> grant stays 0x000008 until lock drops, then busSelect=1 on the next cycle.
REQ-031 Scenario: reset_n pulled low between clock edges during HOLD -> grant=0 and busValid=0 immediately; after release with req=0x800000 -> busSelect=24.

Source files
------------

// File: rtl/bus_drive_arbiter.sv
// Single-owner drive arbiter for the 24-source datapath bus, with lock/hold and forced release.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (R0 highest) otherwise.
module bus_drive_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] req,
    input  logic        lock,
    output logic [23:0] grant,
    output logic [4:0]  busSelect,
    output logic        busValid,
    output logic        holdTimeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_t;

    state_t      state;
    logic [3:0]  hold_count;
    logic        hold_ok;
    logic        at_limit;
    logic        forced;
    logic [23:0] arb_req;
    logic        win_found;
    logic [4:0]  win_idx;

    // grant is one-hot on the owner, so req & grant tests req[owner] without an index.
    assign hold_ok  = (state != IDLE) && lock && (|(req & grant));
    assign at_limit = hold_count >= 4'(MAX_HOLD);
    assign forced   = hold_ok && at_limit;
    assign arb_req  = forced ? (req & ~grant) : req;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [4:0] rr_pointer;
    logic [4:0] scan_idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= 24; i++) begin
            scan_idx = 5'((int'(rr_pointer) + i) % 24);
            if (!win_found && arb_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        // Descending scan: the last hit is the lowest index, i.e. the highest priority.
        for (int i = 23; i >= 0; i--) begin
            if (arb_req[5'(i)]) begin
                win_found = 1'b1;
                win_idx   = 5'(i);
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            busSelect   <= '0;
            busValid    <= 1'b0;
            holdTimeout <= 1'b0;
            hold_count  <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rr_pointer  <= 5'd23;
`endif
        end else if (hold_ok && !at_limit) begin
            state       <= HOLD;
            hold_count  <= hold_count + 4'd1;
            holdTimeout <= 1'b0;
        end else begin
            holdTimeout <= forced;
            hold_count  <= '0;
            if (win_found) begin
                state     <= GRANT;
                grant     <= 24'd1 << win_idx;
                busSelect <= win_idx + 5'd1;
                busValid  <= 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                rr_pointer <= win_idx;
`endif
            end else begin
                state     <= IDLE;
                grant     <= '0;
                busSelect <= '0;
                busValid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed bench for bus_drive_arbiter (default build: fixed priority, MAX_HOLD = 15).
module tb_bus_drive_arbiter;

    logic        clock;
    logic        reset_n;
    logic [23:0] req;
    logic        lock;
    logic [23:0] grant;
    logic [4:0]  busSelect;
    logic        busValid;
    logic        holdTimeout;

    int tests  = 0;
    int failed = 0;

    bus_drive_arbiter #(.MAX_HOLD(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .grant       (grant),
        .busSelect   (busSelect),
        .busValid    (busValid),
        .holdTimeout (holdTimeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [23:0] req;
        logic        lock;
        logic [23:0] exp_grant;
        logic [4:0]  exp_sel;
        logic        exp_valid;
        logic        exp_to;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_outs(input string name, input logic [23:0] eg, input logic [4:0] es,
                              input logic ev, input logic et);
        check({name, " grant"}, 32'(grant), 32'(eg));
        check({name, " busSelect"}, 32'(busSelect), 32'(es));
        check({name, " busValid"}, 32'(busValid), 32'(ev));
        check({name, " holdTimeout"}, 32'(holdTimeout), 32'(et));
    endtask

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic [23:0] r, input logic l);
        req  = r;
        lock = l;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{24'h000005, 1'b0, 24'h000001, 5'd1,  1'b1, 1'b0};
        vecs[1]  = '{24'h000000, 1'b0, 24'h000000, 5'd0,  1'b0, 1'b0};
        vecs[2]  = '{24'h300000, 1'b0, 24'h100000, 5'd21, 1'b1, 1'b0};
        vecs[3]  = '{24'h300000, 1'b0, 24'h100000, 5'd21, 1'b1, 1'b0};
        vecs[4]  = '{24'h300000, 1'b0, 24'h100000, 5'd21, 1'b1, 1'b0};
        vecs[5]  = '{24'h800000, 1'b0, 24'h800000, 5'd24, 1'b1, 1'b0};
        vecs[6]  = '{24'h0000F0, 1'b1, 24'h000010, 5'd5,  1'b1, 1'b0};
        vecs[7]  = '{24'h0000F0, 1'b1, 24'h000010, 5'd5,  1'b1, 1'b0};
        vecs[8]  = '{24'h0000F1, 1'b1, 24'h000010, 5'd5,  1'b1, 1'b0};
        vecs[9]  = '{24'h0000E1, 1'b1, 24'h000001, 5'd1,  1'b1, 1'b0};
        vecs[10] = '{24'h0000E0, 1'b0, 24'h000020, 5'd6,  1'b1, 1'b0};
        vecs[11] = '{24'h010000, 1'b0, 24'h010000, 5'd17, 1'b1, 1'b0};
        vecs[12] = '{24'h020000, 1'b0, 24'h020000, 5'd18, 1'b1, 1'b0};
        vecs[13] = '{24'h000000, 1'b0, 24'h000000, 5'd0,  1'b0, 1'b0};
        vecs[14] = '{24'h400000, 1'b0, 24'h400000, 5'd23, 1'b1, 1'b0};
        vecs[15] = '{24'h000000, 1'b1, 24'h000000, 5'd0,  1'b0, 1'b0};

        reset_n = 1'b0;
        req     = '0;
        lock    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", 24'h0, 5'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req, vecs[i].lock);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_sel,
                       vecs[i].exp_valid, vecs[i].exp_to);
        end

        // Locked HI with no competitor: 16 owned cycles, one forced idle cycle, then re-grant.
        for (int k = 0; k < 16; k++) begin
            step(24'h010000, 1'b1);
            check_outs($sformatf("hold_hi%0d", k), 24'h010000, 5'd17, 1'b1, 1'b0);
        end
        step(24'h010000, 1'b1);
        check_outs("timeout_idle", 24'h0, 5'd0, 1'b0, 1'b1);
        step(24'h010000, 1'b1);
        check_outs("timeout_regrant", 24'h010000, 5'd17, 1'b1, 1'b0);
        step(24'h000000, 1'b0);
        check_outs("timeout_drop", 24'h0, 5'd0, 1'b0, 1'b0);

        // Forced release with a waiting requester hands over with no gap.
        for (int k = 0; k < 16; k++) begin
            step(24'h000030, 1'b1);
            check_outs($sformatf("hold_r4_%0d", k), 24'h000010, 5'd5, 1'b1, 1'b0);
        end
        step(24'h000030, 1'b1);
        check_outs("timeout_handover", 24'h000020, 5'd6, 1'b1, 1'b1);
        step(24'h000030, 1'b1);
        check_outs("after_handover", 24'h000020, 5'd6, 1'b1, 1'b0);
        step(24'h000000, 1'b0);
        check_outs("handover_drop", 24'h0, 5'd0, 1'b0, 1'b0);

        // R3 locked, R0 arrives mid-hold and must wait for the lock to drop.
        step(24'h000008, 1'b1);
        check_outs("r3_grant", 24'h000008, 5'd4, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(24'h000009, 1'b1);
            check_outs($sformatf("r3_nopreempt%0d", k), 24'h000008, 5'd4, 1'b1, 1'b0);
        end
        step(24'h000009, 1'b0);
        check_outs("r0_after_unlock", 24'h000001, 5'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-hold clears outputs before any clock edge.
        step(24'h000008, 1'b1);
        step(24'h000008, 1'b1);
        check_outs("pre_reset_hold", 24'h000008, 5'd4, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 24'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step(24'h800000, 1'b0);
        check_outs("post_reset_c", 24'h800000, 5'd24, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
